// File: rtl/mem_arb_pkg.sv
// ----------------------------------------------------------------------------
// mem_arb_pkg: shared state encoding and grant codes for mem_bus_arbiter. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

endpackage

`default_nettype wire

// File: rtl/mem_arb_timeout.sv
// ----------------------------------------------------------------------------
// mem_arb_timeout: wait-state counter that flags an abort on the last allowed stall cycle. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mem_arb_timeout #(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 9
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic inc_i,
  output logic abort_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  generate
    if (TIMEOUT != 0) begin : g_tmo_en
      localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TIMEOUT - 1);
      assign abort_o = inc_i & (cnt_q == C_LAST);
    end else begin : g_tmo_dis
      assign abort_o = 1'b0;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
// ----------------------------------------------------------------------------
// mem_bus_arbiter: round-robin, lockable two-master arbiter for the external memory bus. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 24,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic              m0_re_i,
  input  logic              m0_we_i,
  input  logic              m0_lock_i,
  input  logic [DATA_W-1:0] m0_data_i,
  output logic [DATA_W-1:0] m0_data_o,
  output logic              m0_needWait_o,
  output logic              m0_err_o,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic              m1_re_i,
  input  logic              m1_we_i,
  input  logic              m1_lock_i,
  input  logic [DATA_W-1:0] m1_data_i,
  output logic [DATA_W-1:0] m1_data_o,
  output logic              m1_needWait_o,
  output logic              m1_err_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              re_o,
  output logic              we_o,
  inout  wire  [DATA_W-1:0] data_io,
  input  logic              needWait_i,
  output logic [1:0]        gnt_o
);

  arb_state_t state_q, state_d;
  logic       last_gnt_q, last_gnt_d;   // 1: M1 was served last

  logic              w_req0, w_req1;
  logic              w_own0, w_own1;
  logic              w_own_req, w_own_lock, w_oth_req;
  logic              w_abort, w_done, w_inc, w_clr;
  logic [DATA_W-1:0] w_wdata;

  assign w_req0     = m0_re_i | m0_we_i;
  assign w_req1     = m1_re_i | m1_we_i;
  assign w_own0     = (state_q == ARB_OWN0);
  assign w_own1     = (state_q == ARB_OWN1);
  assign w_own_req  = (w_own0 & w_req0) | (w_own1 & w_req1);
  assign w_own_lock = (w_own0 & m0_lock_i) | (w_own1 & m1_lock_i);
  assign w_oth_req  = (w_own0 & w_req1) | (w_own1 & w_req0);
  assign w_inc      = w_own_req & needWait_i;
  assign w_done     = w_own_req & (~needWait_i | w_abort);
  assign w_clr      = w_done | (state_d != state_q);

  mem_arb_timeout #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (w_clr),
    .inc_i   (w_inc),
    .abort_o (w_abort)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ARB_IDLE;
      last_gnt_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (w_req0 && w_req1) begin
          state_d = last_gnt_q ? ARB_OWN0 : ARB_OWN1;
        end else if (w_req0) begin
          state_d = ARB_OWN0;
        end else if (w_req1) begin
          state_d = ARB_OWN1;
        end
      end
      ARB_OWN0, ARB_OWN1: begin
        if (w_done) begin
          last_gnt_d = w_own1;
          // A timeout abort releases the bus even under lock.
          if (!(w_own_lock && !w_abort)) begin
            if (w_oth_req) begin
              state_d = w_own0 ? ARB_OWN1 : ARB_OWN0;
            end else begin
              state_d = ARB_IDLE;
            end
          end
        end else if (!w_own_req && !w_own_lock) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    addr_o  = '0;
    re_o    = 1'b0;
    we_o    = 1'b0;
    w_wdata = '0;
    gnt_o   = GNT_NONE;
    if (w_own0) begin
      addr_o  = m0_addr_i;
      re_o    = m0_re_i;
      we_o    = m0_we_i & ~m0_re_i;
      w_wdata = m0_data_i;
      gnt_o   = GNT_M0;
    end else if (w_own1) begin
      addr_o  = m1_addr_i;
      re_o    = m1_re_i;
      we_o    = m1_we_i & ~m1_re_i;
      w_wdata = m1_data_i;
      gnt_o   = GNT_M1;
    end
  end

  assign data_io = we_o ? w_wdata : {DATA_W{1'bz}};

  assign m0_needWait_o = w_own0 ? (needWait_i & ~w_abort) : 1'b1;
  assign m1_needWait_o = w_own1 ? (needWait_i & ~w_abort) : 1'b1;
  assign m0_err_o      = w_own0 & w_abort;
  assign m1_err_o      = w_own1 & w_abort;
  assign m0_data_o     = (w_own0 & re_o) ? data_io : '0;
  assign m1_data_o     = (w_own1 & re_o) ? data_io : '0;

endmodule

`default_nettype wire
